// File: rtl/sb_pkg.sv
// sb_pkg: shared types for the forwarding scoreboard.
// Slot entry layout, forward-select encoding and select width.
package sb_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_DEPTH  = 3;
  localparam int SB_LAT_W  = 2;

  // forward select 0 means "read the register file"
  localparam int FS_NONE = 0;

  function automatic int fs_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 vld;
    logic [SB_REG_AW-1:0] dst;
    logic [SB_LAT_W-1:0]  lat;
  } sb_entry_t;

endpackage

// File: rtl/sb_md_counter.sv
// sb_md_counter: countdown for one in-flight multicycle result.
// Holds the destination register while the countdown is nonzero.
import sb_pkg::*;

module sb_md_counter #(
  parameter int REG_AW  = SB_REG_AW,
  parameter int MDCNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MDCNT_W-1:0] cycles,
  input  logic [REG_AW-1:0]  dst_in,
  output logic               busy,
  output logic               done,
  output logic [REG_AW-1:0]  dst
);

  logic [MDCNT_W-1:0] cnt_q;
  logic               done_q;
  logic [REG_AW-1:0]  dst_q;

  // load on accepted start, count down to zero, pulse after 1->0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      dst_q  <= '0;
    end else begin
      done_q <= (cnt_q == MDCNT_W'(1));
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - MDCNT_W'(1);
      end else if (load) begin
        cnt_q <= cycles;
        dst_q <= dst_in;
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign dst  = dst_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: slot-based dependency tracker with forward selects.
// Optional stall counter enabled by SB_STALL_CNT_EN.
import sb_pkg::*;

module fwd_scoreboard #(
  parameter int REG_AW  = SB_REG_AW,
  parameter int NSRC    = 2,
  parameter int DEPTH   = SB_DEPTH,
  parameter int MDCNT_W = 6,
  localparam int FS_W   = fs_w(DEPTH),
  localparam int LAT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_vld,
  input  logic                   issue_wr,
  input  logic [REG_AW-1:0]      issue_dst,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_used,
  input  logic                   stall_in,
  input  logic                   flush_in,
  input  logic                   md_start,
  input  logic [REG_AW-1:0]      md_dst,
  input  logic [MDCNT_W-1:0]     md_cycles,
  output logic [NSRC*FS_W-1:0]   fwd_sel,
  output logic                   stall_req,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [31:0]            stall_cnt
);

  sb_entry_t         slot_q [DEPTH];
  sb_entry_t         issue_entry;
  logic [NSRC-1:0]   src_wait;
  logic [NSRC-1:0]   md_hit;
  logic [REG_AW-1:0] md_dst_q;
  logic              md_load;

  assign issue_entry = {issue_vld & issue_wr, issue_dst, issue_lat};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [REG_AW-1:0] addr;
    logic [FS_W-1:0]   sel;
    logic              wait_s;

    assign addr = src_addr[s*REG_AW +: REG_AW];

    // youngest matching slot decides: forward from it or wait
    always_comb begin
      sel    = FS_W'(FS_NONE);
      wait_s = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_q[k].vld && slot_q[k].dst == addr &&
            addr != '0 && src_used[s]) begin
          if (k >= int'(slot_q[k].lat)) begin
            sel    = FS_W'(k + 1);
            wait_s = 1'b0;
          end else begin
            sel    = FS_W'(FS_NONE);
            wait_s = 1'b1;
          end
        end
      end
    end

    assign fwd_sel[s*FS_W +: FS_W] = sel;
    assign src_wait[s] = wait_s;
    assign md_hit[s] = src_used[s] && addr != '0 && addr == md_dst_q;
  end

  assign stall_req = (|src_wait) |
                     (md_busy & (|md_hit)) |
                     (md_start & md_busy);

  assign md_load = md_start & ~md_busy & ~stall_req;

  sb_md_counter #(
    .REG_AW  (REG_AW),
    .MDCNT_W (MDCNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .cycles (md_cycles),
    .dst_in (md_dst),
    .busy   (md_busy),
    .done   (md_done),
    .dst    (md_dst_q)
  );

  // advance slots; external stall freezes them, flush kills slot 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else if (stall_in) begin
      if (flush_in) slot_q[0] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) slot_q[k] <= slot_q[k-1];
      slot_q[0] <= (stall_req | flush_in) ? '0 : issue_entry;
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // saturating count of cycles with stall_req high
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_req && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed table plus randomized model check.
// Model tracks in-flight writes by age and a remaining-cycles count.
module tb_fwd_scoreboard;
  import sb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_vld;
  logic        issue_wr;
  logic [4:0]  issue_dst;
  logic [1:0]  issue_lat;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic        stall_in;
  logic        flush_in;
  logic        md_start;
  logic [4:0]  md_dst;
  logic [5:0]  md_cycles;
  logic [3:0]  fwd_sel;
  logic        stall_req;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .issue_vld (issue_vld),
    .issue_wr  (issue_wr),
    .issue_dst (issue_dst),
    .issue_lat (issue_lat),
    .src_addr  (src_addr),
    .src_used  (src_used),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
    .md_start  (md_start),
    .md_dst    (md_dst),
    .md_cycles (md_cycles),
    .fwd_sel   (fwd_sel),
    .stall_req (stall_req),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    bit       rst;
    bit       ivld;
    bit       iwr;
    bit [4:0] idst;
    bit [1:0] ilat;
    bit [4:0] s0;
    bit [4:0] s1;
    bit [1:0] u;
    bit       stl;
    bit       fl;
    bit       mds;
    bit [4:0] mdd;
    bit [5:0] mdc;
    bit       chk;
    bit [1:0] e0;
    bit [1:0] e1;
    bit       es;
    bit       eb;
    bit       ed;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference: writes in flight, indexed by age (0 = most recent)
  bit          m_vld [3];
  bit [4:0]    m_dst [3];
  int          m_lat [3];
  int          m_left;
  bit [4:0]    m_mdd;
  bit          m_done;
  logic [31:0] m_scnt;

  function automatic vec_t v(
    input bit rst, input bit ivld, input bit iwr,
    input bit [4:0] idst, input bit [1:0] ilat,
    input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] u,
    input bit stl, input bit fl, input bit mds,
    input bit [4:0] mdd, input bit [5:0] mdc,
    input bit [1:0] e0, input bit [1:0] e1,
    input bit es, input bit eb, input bit ed);
    vec_t t;
    t.rst = rst; t.ivld = ivld; t.iwr = iwr;
    t.idst = idst; t.ilat = ilat;
    t.s0 = s0; t.s1 = s1; t.u = u;
    t.stl = stl; t.fl = fl; t.mds = mds;
    t.mdd = mdd; t.mdc = mdc;
    t.chk = !rst;
    t.e0 = e0; t.e1 = e1; t.es = es; t.eb = eb; t.ed = ed;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void src_eval(input bit [4:0] a, input bit used,
                                   output bit [1:0] sel, output bit wt,
                                   output bit mh);
    bit found;
    sel = 2'd0;
    wt = 1'b0;
    found = 1'b0;
    mh = used && a != 5'd0 && m_left > 0 && a == m_mdd;
    if (used && a != 5'd0) begin
      for (int age = 0; age < 3; age++) begin
        if (!found && m_vld[age] && m_dst[age] == a) begin
          found = 1'b1;
          if (age >= m_lat[age]) sel = 2'(age + 1);
          else wt = 1'b1;
        end
      end
    end
  endfunction

  task automatic model_update(input vec_t t, input bit stl_req);
    if (t.rst) begin
      for (int i = 0; i < 3; i++) begin
        m_vld[i] = 1'b0; m_dst[i] = '0; m_lat[i] = 0;
      end
      m_left = 0; m_mdd = '0; m_done = 1'b0; m_scnt = '0;
      return;
    end
`ifdef SB_STALL_CNT_EN
    if (stl_req && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
`endif
    m_done = (m_left == 1);
    if (m_left > 0) m_left = m_left - 1;
    else if (t.mds && !stl_req) begin
      m_left = int'(t.mdc);
      m_mdd = t.mdd;
    end
    if (t.stl) begin
      if (t.fl) m_vld[0] = 1'b0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_vld[i] = m_vld[i-1]; m_dst[i] = m_dst[i-1]; m_lat[i] = m_lat[i-1];
      end
      m_vld[0] = t.ivld && t.iwr && !stl_req && !t.fl;
      m_dst[0] = t.idst;
      m_lat[0] = int'(t.ilat);
    end
  endtask

  task automatic step(input vec_t t, input bit use_tbl);
    bit [1:0] sel0, sel1;
    bit w0, w1, h0, h1, ms;
    @(negedge clk);
    reset = t.rst;
    issue_vld = t.ivld; issue_wr = t.iwr;
    issue_dst = t.idst; issue_lat = t.ilat;
    src_addr = {t.s1, t.s0}; src_used = t.u;
    stall_in = t.stl; flush_in = t.fl;
    md_start = t.mds; md_dst = t.mdd; md_cycles = t.mdc;
    #1;
    src_eval(t.s0, t.u[0], sel0, w0, h0);
    src_eval(t.s1, t.u[1], sel1, w1, h1);
    ms = w0 || w1 || ((h0 || h1) && m_left > 0) ||
         (t.mds && m_left > 0);
    if (t.chk) begin
      if (use_tbl) begin
        check("sel0", 32'(fwd_sel[1:0]), 32'(t.e0));
        check("sel1", 32'(fwd_sel[3:2]), 32'(t.e1));
        check("stall", 32'(stall_req), 32'(t.es));
        check("busy", 32'(md_busy), 32'(t.eb));
        check("done", 32'(md_done), 32'(t.ed));
      end else begin
        check("rsel0", 32'(fwd_sel[1:0]), 32'(sel0));
        check("rsel1", 32'(fwd_sel[3:2]), 32'(sel1));
        check("rstall", 32'(stall_req), 32'(ms));
        check("rbusy", 32'(md_busy), 32'(m_left > 0));
        check("rdone", 32'(md_done), 32'(m_done));
      end
      check("stall_cnt", stall_cnt, m_scnt);
    end
    model_update(t, ms);
    cyc++;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t r;
    reset = 1'b1; issue_vld = 0; issue_wr = 0; issue_dst = '0;
    issue_lat = '0; src_addr = '0; src_used = '0; stall_in = 0;
    flush_in = 0; md_start = 0; md_dst = '0; md_cycles = '0;
    m_left = 0; m_done = 0; m_mdd = '0; m_scnt = '0;
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 0; m_dst[i] = '0; m_lat[i] = 0;
    end

    // reset and reset state
    tbl.push_back(v(1,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,2,3, 0,0,0,0,0, 0,0,0,0,0));
    // ALU result r3
    tbl.push_back(v(0,1,1,3,1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,1,9,1, 3,0,1, 0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 3,9,3, 0,0,0,0,0, 2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 3,0,1, 0,0,0,0,0, 3,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 3,0,1, 0,0,0,0,0, 0,0,0,0,0));
    // load-use r4
    tbl.push_back(v(0,1,1,4,2, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,4,2, 0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,4,2, 0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,4,2, 0,0,0,0,0, 0,3,0,0,0));
    // double write r5
    tbl.push_back(v(0,1,1,5,1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,1,8,1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,1,5,1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 5,8,3, 0,0,0,0,0, 0,2,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 5,8,3, 0,0,0,0,0, 2,3,0,0,0));
    // r0 never matches
    tbl.push_back(v(0,1,1,0,1, 0,5,3, 0,0,0,0,0, 0,3,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1, 0,0,0,0,0, 0,0,0,0,0));
    // external stall and flush
    tbl.push_back(v(0,1,1,6,1, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,1,1,10,2, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0,0,0,0,0, 6,10,3, 1,0,0,0,0, 2,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 6,10,3, 1,1,0,0,0, 2,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 6,10,3, 0,0,0,0,0, 2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 6,0,1, 0,0,0,0,0, 3,0,0,0,0));
    tbl.push_back(v(0,1,1,11,1, 0,0,0, 0,1,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 11,0,1, 0,0,0,0,0, 0,0,0,0,0));
    // multicycle r7, 4 cycles; start while busy ignored
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,1,7,4, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,1,12,2, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,0,0,0));
    // reset during countdown
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,1,7,4, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,1,0));
    tbl.push_back(v(1,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,1, 0,0,0,0,0, 0,0,0,0,0));
    // start blocked by a load-use stall
    tbl.push_back(v(0,1,1,4,2, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 4,0,1, 0,0,1,13,3, 0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,13,2, 0,0,0,0,0, 0,0,0,0,0));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // randomized run against the reference
    step(v(1,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0), 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r.rst  = ($urandom_range(0, 99) == 0);
      r.ivld = ($urandom_range(0, 3) != 0);
      r.iwr  = ($urandom_range(0, 3) != 0);
      r.idst = 5'($urandom_range(0, 7));
      r.ilat = 2'($urandom_range(0, 2));
      r.s0   = 5'($urandom_range(0, 7));
      r.s1   = 5'($urandom_range(0, 7));
      r.u    = 2'($urandom_range(0, 3));
      r.stl  = ($urandom_range(0, 5) == 0);
      r.fl   = ($urandom_range(0, 7) == 0);
      r.mds  = ($urandom_range(0, 7) == 0);
      r.mdd  = 5'($urandom_range(0, 7));
      r.mdc  = 6'($urandom_range(1, 6));
      r.chk  = !r.rst;
      r.e0 = '0; r.e1 = '0; r.es = 0; r.eb = 0; r.ed = 0;
      step(r, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
